link_anim_sequencer: RTL

//  Sequences the player sprite animation: selects which sprite ROM/palette

---
 rtl/link_anim_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/link_anim_sequencer.sv
// link_anim_sequencer: per-frame player sprite pose/direction sequencer (walk cycle and 4-frame sword attack)
module link_anim_sequencer #(
  parameter int WALK_TICKS = 8,
  parameter int ATK_TICKS = 4,
  parameter int CNT_W = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       move_valid,
  input  logic [1:0] move_dir,
  input  logic       attack_req,
  output logic [1:0] dir,
  output logic [2:0] pose,
  output logic       busy,
  output logic       attack_done
);
  typedef enum logic [1:0] {IDLE, WALK, ATTACK} state_t;
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] ATK_LAST = CNT_W'(ATK_TICKS - 1);
  state_t state, state_n;
  logic [1:0] dir_n;
  logic [2:0] pose_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic atk_pending, pending_n, done_n, busy_n, atk_eff;
  assign atk_eff = atk_pending | attack_req;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      dir <= 2'd1;
      pose <= 3'd0;
      cnt <= '0;
      atk_pending <= 1'b0;
      busy <= 1'b0;
      attack_done <= 1'b0;
    end else begin
      state <= state_n;
      dir <= dir_n;
      pose <= pose_n;
      cnt <= cnt_n;
      atk_pending <= pending_n;
      busy <= busy_n;
      attack_done <= done_n;
    end
  always_comb begin
    state_n = state;
    dir_n = dir;
    pose_n = pose;
    cnt_n = cnt;
    done_n = 1'b0;
    if (frame_tick)
      case (state)
        IDLE: begin
          cnt_n = '0;
          pose_n = atk_eff ? 3'd2 : 3'd0;
          state_n = atk_eff ? ATTACK : move_valid ? WALK : IDLE;
          dir_n = (!atk_eff && move_valid) ? move_dir : dir;
        end
        WALK: begin
          if (atk_eff) begin
            state_n = ATTACK;
            pose_n = 3'd2;
            cnt_n = '0;
          end else if (!move_valid) begin
            state_n = IDLE;
            pose_n = 3'd0;
            cnt_n = '0;
          end else if (move_dir != dir) begin
            dir_n = move_dir;
            pose_n = 3'd0;
            cnt_n = '0;
          end else begin
            cnt_n = (cnt == WALK_LAST) ? '0 : cnt + 1'b1;
            pose_n = (cnt == WALK_LAST) ? {2'b00, ~pose[0]} : pose;
          end
        end
        default: begin
          if (cnt != ATK_LAST) cnt_n = cnt + 1'b1;
          else if (pose != 3'd5) begin
            cnt_n = '0;
            pose_n = pose + 3'd1;
          end else begin
            done_n = 1'b1;
            cnt_n = '0;
            pose_n = 3'd0;
            state_n = move_valid ? WALK : IDLE;
            dir_n = move_valid ? move_dir : dir;
          end
        end
      endcase
    // a request seen outside ATTACK waits for the next tick, which always consumes it
    pending_n = (state != ATTACK) && !frame_tick && atk_eff;
    // busy covers the done cycle so it drops only on the cycle after attack_done
    busy_n = (state_n == ATTACK) || done_n;
  end
endmodule
